// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one instruction/data memory between the fetch and MEM stages.
// Data requests take priority, but fetch is forced after STARVE_MAX back-to-back data grants.
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    input  logic [31:0] m_rdata,
    output logic        busy
);
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [1:0] LAST = 2'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    state_t        state;
    logic [1:0]    lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_d;
    assign grant_d  = d_req && (!if_req || starve_cnt < SMAX);
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;
    // The m_* registers double as the latched command; they are zero outside the access window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            d_rdata    <= '0;
            d_valid    <= 1'b0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_size     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (grant_d) begin
                        state      <= BUSY_D;
                        busy       <= 1'b1;
                        m_en       <= 1'b1;
                        m_we       <= d_we;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        m_size     <= d_size;
                        starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
                    end else if (if_req) begin
                        state      <= BUSY_I;
                        busy       <= 1'b1;
                        m_en       <= 1'b1;
                        m_addr     <= if_addr;
                        starve_cnt <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LAST) begin
                        lat_cnt <= '0;
                        state   <= RESP;
                        m_en    <= 1'b0;
                        m_we    <= 1'b0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        m_size  <= '0;
                        // A fetch withdrawn before capture was flushed by a branch: drop the result.
                        if (state == BUSY_I && if_req) begin
                            if_rdata <= m_rdata;
                            if_valid <= 1'b1;
                        end
                        if (state == BUSY_D) begin
                            d_valid <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    if_valid <= 1'b0;
                    d_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of arbitration, latency, starvation, store, cancel and reset.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid, if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_rdata;
    logic        d_valid, d_stall;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [31:0] m_rdata = '0;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] order [6];

    unified_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        order = '{32'h300, 32'h300, 32'h30, 32'h300, 32'h300, 32'h30};
        repeat (2) tick();
        chk("rst_m_en", {31'b0, m_en}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_valids", {30'b0, if_valid, d_valid}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        rst = 1'b0;
        tick();
        // fetch only
        if_req = 1'b1; if_addr = 32'h10; m_rdata = 32'h0050_0093;
        #1 chk("f_stall_c0", {31'b0, if_stall}, 1);
        tick();
        chk("f_m_en_c1", {31'b0, m_en}, 1);
        chk("f_m_addr_c1", m_addr, 32'h10);
        chk("f_m_we_c1", {31'b0, m_we}, 0);
        chk("f_busy_c1", {31'b0, busy}, 1);
        tick();
        chk("f_m_en_c2", {31'b0, m_en}, 1);
        chk("f_valid_c2", {31'b0, if_valid}, 0);
        chk("f_stall_c2", {31'b0, if_stall}, 1);
        tick();
        chk("f_valid_c3", {31'b0, if_valid}, 1);
        chk("f_rdata_c3", if_rdata, 32'h0050_0093);
        chk("f_stall_c3", {31'b0, if_stall}, 0);
        chk("f_m_en_c3", {31'b0, m_en}, 0);
        tick();
        if_req = 1'b0;
        chk("f_valid_c4", {31'b0, if_valid}, 0);
        tick();
        chk("f_idle_busy", {31'b0, busy}, 0);
        // simultaneous fetch and load: data first
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_size = 2'd2; m_rdata = 32'h1122_3344;
        tick();
        chk("sd_m_addr", m_addr, 32'h200);
        chk("sd_m_we", {31'b0, m_we}, 0);
        chk("sd_m_size", {30'b0, m_size}, 2);
        tick();
        tick();
        chk("sd_d_valid", {31'b0, d_valid}, 1);
        chk("sd_d_rdata", d_rdata, 32'h1122_3344);
        chk("sd_d_stall", {31'b0, d_stall}, 0);
        chk("sd_if_stall", {31'b0, if_stall}, 1);
        tick();
        d_req = 1'b0; m_rdata = 32'hAABB_CCDD;
        chk("sd_if_stall_idle", {31'b0, if_stall}, 1);
        tick();
        chk("si_m_addr", m_addr, 32'h20);
        chk("si_m_size", {30'b0, m_size}, 0);
        tick();
        tick();
        chk("si_if_valid", {31'b0, if_valid}, 1);
        chk("si_if_rdata", if_rdata, 32'hAABB_CCDD);
        tick();
        if_req = 1'b0;
        tick();
        // starvation: D, D, I, D, D, I
        if_req = 1'b1; if_addr = 32'h30;
        d_req = 1'b1; d_addr = 32'h300; m_rdata = 32'h0000_0055;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("starve_order%0d", i), m_addr, order[i]);
            tick();
            tick();
            chk($sformatf("starve_valid%0d", i), {30'b0, if_valid, d_valid},
                (order[i] == 32'h30) ? 32'd2 : 32'd1);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        // store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_size = 2'd2;
        m_rdata = 32'h9999_9999;
        tick();
        chk("st_m_we_c1", {31'b0, m_we}, 1);
        chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("st_m_addr", m_addr, 32'h40);
        tick();
        chk("st_m_we_c2", {31'b0, m_we}, 1);
        tick();
        chk("st_d_valid", {31'b0, d_valid}, 1);
        chk("st_d_rdata_kept", d_rdata, 32'h0000_0055);
        chk("st_m_we_resp", {31'b0, m_we}, 0);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        chk("st_d_valid_off", {31'b0, d_valid}, 0);
        tick();
        // fetch cancel with pending load
        if_req = 1'b1; if_addr = 32'h50; m_rdata = 32'h7777_7777;
        tick();
        chk("fc_m_addr", m_addr, 32'h50);
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h600;
        tick();
        tick();
        chk("fc_no_valid", {31'b0, if_valid}, 0);
        chk("fc_if_rdata", if_rdata, 32'h0000_0055);
        chk("fc_busy_resp", {31'b0, busy}, 1);
        tick();
        chk("fc_no_valid_idle", {31'b0, if_valid}, 0);
        tick();
        chk("fc_d_grant", m_addr, 32'h600);
        tick();
        tick();
        chk("fc_d_valid", {31'b0, d_valid}, 1);
        chk("fc_d_rdata", d_rdata, 32'h7777_7777);
        tick();
        d_req = 1'b0;
        tick();
        // reset in the first BUSY_D cycle
        d_req = 1'b1; d_addr = 32'h700; m_rdata = 32'h1234_5678;
        tick();
        chk("rb_m_en_pre", {31'b0, m_en}, 1);
        rst = 1'b1;
        #1;
        chk("rb_m_en", {31'b0, m_en}, 0);
        chk("rb_m_addr", m_addr, 0);
        chk("rb_busy", {31'b0, busy}, 0);
        chk("rb_d_rdata", d_rdata, 0);
        chk("rb_if_rdata", if_rdata, 0);
        tick();
        chk("rb_no_d_valid", {31'b0, d_valid}, 0);
        rst = 1'b0;
        tick();
        chk("rb_regrant", m_addr, 32'h700);
        tick();
        chk("rb_valid_early", {31'b0, d_valid}, 0);
        tick();
        chk("rb_d_valid", {31'b0, d_valid}, 1);
        chk("rb_d_rdata", d_rdata, 32'h1234_5678);
        tick();
        d_req = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares the single unified instruction/data memory of the pipelined RISC-V core between the fetch stage (IF port) and the MEM stage (D port, loads/stores). Arbitrates each access, drives the memory for a fixed MEM_LAT-cycle access window and returns read data with a one-cycle valid pulse. Generates the per-port stall signals the hazard logic uses to freeze the pipeline. Data access has priority; a bounded-starvation counter guarantees fetch progress.

Parameters:
MEM_LAT, 2, memory access cycles per transaction; legal range 1..4
STARVE_MAX, 2, max consecutive data grants while fetch is waiting before fetch is forced

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, level, held until if_valid or cancel
if_addr  in  32  fetch byte address
if_rdata  out  32  fetched instruction, registered
if_valid  out  1  one-cycle pulse, if_rdata valid
if_stall  out  1  if_req & ~if_valid
d_req  in  1  data request, level, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_size  in  2  funct3[1:0] access size, passed to memory
d_rdata  out  32  load data, registered
d_valid  out  1  one-cycle pulse, load data valid / store done
d_stall  out  1  d_req & ~d_valid
m_en  out  1  memory enable, high throughout the access window
m_we  out  1  memory write enable
m_addr  out  32  memory address
m_wdata  out  32  memory write data
m_size  out  2  memory access size
m_rdata  in  32  memory read data, valid in last access-window cycle
busy  out  1  access in progress (state != IDLE)

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset -> IDLE.
- Reset values: all outputs 0, lat_cnt 0, starve_cnt 0, owner reg 0. Reset mid-access aborts immediately; no valid pulse follows.
- IDLE arbitration (sampled each edge):
  - d_req & (~if_req | starve_cnt < STARVE_MAX) -> BUSY_D
  - else if_req -> BUSY_I
  - else stay IDLE
- On grant: latch addr/we/wdata/size into command regs; m_* driven only from these regs. m_we = 1 only in BUSY_D with latched we = 1; fetch never writes. m_wdata and m_size are 0 in BUSY_I.
- starve_cnt: +1 on data grant while if_req = 1 (saturates at STARVE_MAX); cleared on fetch grant or in IDLE with if_req = 0.
- BUSY_x: m_en = 1; lat_cnt counts 0..MEM_LAT-1. At lat_cnt = MEM_LAT-1, capture m_rdata into if_rdata (BUSY_I) or d_rdata (BUSY_D read) -> RESP.
- Stores never update d_rdata.
- RESP: one cycle; pulse the owner's valid -> IDLE. m_en = 0.
- Latency: request first seen at edge E -> valid high in cycle starting at edge E+MEM_LAT+1. Minimum back-to-back spacing is MEM_LAT+2 cycles.
- Requester drops req in the cycle after valid; IDLE then sees the updated req level, so there is no double grant.
- Fetch cancel (branch flush): if if_req = 0 at the capture edge of BUSY_I, the access completes, if_rdata is unchanged and no if_valid pulse is generated.
- Withdrawing d_req mid-access is a protocol violation; behaviour is undefined.
- if_addr/d_addr changes during the access window are ignored (latched).
- Stalls are combinational from req and registered valid.

Test Plan:
- Fetch only, MEM_LAT = 2, if_req with if_addr = 0x10 at edge 0, m_rdata = 0x00500093 -> m_en high for cycles 1–2 with m_addr = 0x10; if_valid pulses in cycle 3 with if_rdata = 0x00500093; if_stall high in cycles 0–2.
- Simultaneous if_req and load d_addr = 0x200 -> data served first (m_we = 0, m_addr = 0x200); fetch is granted at the next IDLE; d_rdata is correct and if_stall stays high throughout.
- Starvation, STARVE_MAX = 2, d_req held through three loads with if_req high -> order is D, D, I, D; starve_cnt returns to 0 after the fetch grant.
- Store d_addr = 0x40, d_wdata = 0xDEADBEEF, d_size = 2 -> m_we = 1 for MEM_LAT cycles, d_valid pulses, d_rdata unchanged from its previous load value.
- Fetch cancel: drop if_req during BUSY_I -> no if_valid, if_rdata unchanged, next pending d_req is granted.
- Assert rst in BUSY_D cycle 1 -> all outputs 0 immediately; no d_valid pulse; after release, a fresh request is served with normal latency.
